// File: rtl/cache_fill_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cache_fill_ctrl_if : CPU, determine_hit and memory signals of the fill ctrl |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface cache_fill_ctrl_if #(
  parameter int D_WIDTH = 8,
  parameter int A_WIDTH = 8
);
  logic                   req;
  logic [A_WIDTH-1:0]     addr;
  logic                   hit;
  logic [1:0]             sel;
  logic [4*A_WIDTH-1:0]   tag_out;
  logic [3:0]             valid_out;
  logic                   ready;
  logic                   rvalid;
  logic [D_WIDTH-1:0]     rdata;
  logic                   mem_req;
  logic [A_WIDTH-1:0]     mem_addr;
  logic                   mem_ack;
  logic [D_WIDTH-1:0]     mem_data;

  modport master (
    output req, addr, hit, sel, mem_ack, mem_data,
    input  tag_out, valid_out, ready, rvalid, rdata, mem_req, mem_addr
  );

  modport slave (
    input  req, addr, hit, sel, mem_ack, mem_data,
    output tag_out, valid_out, ready, rvalid, rdata, mem_req, mem_addr
  );
endinterface
`default_nettype wire

// File: rtl/cache_fill_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cache_fill_ctrl : 4-entry fully-associative read cache fill controller      |
// | with LRU replacement. Optional hit/miss counters under CACHE_STATS_EN.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module cache_fill_ctrl #(
  parameter int D_WIDTH = 8,
  parameter int A_WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
`ifdef CACHE_STATS_EN
  output logic [7:0] hit_cnt,
  output logic [7:0] miss_cnt,
`endif
  cache_fill_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, FILL = 2'd2} state_t;

  state_t                       state_q, state_d;
  logic [3:0][A_WIDTH-1:0]      tag_q, tag_d;
  logic [3:0]                   valid_q, valid_d;
  logic [3:0][D_WIDTH-1:0]      data_q, data_d;
  logic [3:0][1:0]              cnt_q, cnt_d;
  logic [1:0]                   victim_q, victim_d;
  logic [A_WIDTH-1:0]           mem_addr_q, mem_addr_d;
  logic                         mem_req_q, mem_req_d;
  logic [D_WIDTH-1:0]           fill_buf_q, fill_buf_d;
  logic [D_WIDTH-1:0]           rdata_q, rdata_d;
  logic                         rvalid_q, rvalid_d;
  logic [1:0]                   victim_w;

  // Most-recently-used entry becomes 3; entries above its old rank move down one.
  function automatic logic [3:0][1:0] lru_touch(input logic [3:0][1:0] c,
                                                input logic [1:0] idx);
    logic [3:0][1:0] res;
    res = c;
    for (int j = 0; j < 4; j++) begin
      if (c[j] > c[idx]) res[j] = c[j] - 2'd1;
    end
    res[idx] = 2'd3;
    return res;
  endfunction

  // Lowest invalid entry wins over the LRU entry (cnt==0).
  always_comb begin
    victim_w = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (cnt_q[i] == 2'd0) victim_w = 2'(i);
    end
    for (int i = 3; i >= 0; i--) begin
      if (!valid_q[i]) victim_w = 2'(i);
    end
  end

  always_comb begin
    state_d    = state_q;
    tag_d      = tag_q;
    valid_d    = valid_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    victim_d   = victim_q;
    mem_addr_d = mem_addr_q;
    mem_req_d  = mem_req_q;
    fill_buf_d = fill_buf_q;
    rdata_d    = rdata_q;
    rvalid_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req) begin
          if (bus.hit) begin
            rdata_d  = data_q[bus.sel];
            rvalid_d = 1'b1;
            cnt_d    = lru_touch(cnt_q, bus.sel);
          end else begin
            mem_addr_d = bus.addr;
            victim_d   = victim_w;
            mem_req_d  = 1'b1;
            state_d    = FETCH;
          end
        end
      end
      FETCH: begin
        if (bus.mem_ack) begin
          fill_buf_d = bus.mem_data;
          mem_req_d  = 1'b0;
          state_d    = FILL;
        end
      end
      FILL: begin
        tag_d[victim_q]   = mem_addr_q;
        data_d[victim_q]  = fill_buf_q;
        valid_d[victim_q] = 1'b1;
        cnt_d             = lru_touch(cnt_q, victim_q);
        rdata_d           = fill_buf_q;
        rvalid_d          = 1'b1;
        state_d           = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tag_q      <= '0;
      valid_q    <= '0;
      data_q     <= '0;
      cnt_q      <= {2'd3, 2'd2, 2'd1, 2'd0};
      victim_q   <= 2'd0;
      mem_addr_q <= '0;
      mem_req_q  <= 1'b0;
      fill_buf_q <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      tag_q      <= tag_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      victim_q   <= victim_d;
      mem_addr_q <= mem_addr_d;
      mem_req_q  <= mem_req_d;
      fill_buf_q <= fill_buf_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
    end
  end

  assign bus.tag_out   = tag_q;
  assign bus.valid_out = valid_q;
  assign bus.ready     = (state_q == IDLE);
  assign bus.rvalid    = rvalid_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_addr  = mem_addr_q;

`ifdef CACHE_STATS_EN
  logic [7:0] hit_cnt_q, hit_cnt_d;
  logic [7:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == IDLE && bus.req) begin
      if (bus.hit) begin
        if (hit_cnt_q != 8'hFF) hit_cnt_d = hit_cnt_q + 8'd1;
      end else begin
        if (miss_cnt_q != 8'hFF) miss_cnt_d = miss_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= 8'd0;
      miss_cnt_q <= 8'd0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_fill_ctrl.sv
`default_nettype none
// Self-checking bench for cache_fill_ctrl: directed scenarios plus randomized
// read traffic compared against a recency-list cache model.
module tb_cache_fill_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  cache_fill_ctrl_if #(.D_WIDTH(8), .A_WIDTH(8)) bus ();

`ifdef CACHE_STATS_EN
  logic [7:0] hit_cnt;
  logic [7:0] miss_cnt;
`endif

  cache_fill_ctrl #(.D_WIDTH(8), .A_WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef CACHE_STATS_EN
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt),
`endif
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // Reference model: contents plus a recency list (front = least recent).
  logic [7:0] m_tag  [4];
  logic [7:0] m_data [4];
  bit         m_valid[4];
  int         m_order[$];
  int         m_hits, m_misses;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_tag[i] = 8'h00; m_data[i] = 8'h00; m_valid[i] = 1'b0;
    end
    m_order  = '{0, 1, 2, 3};
    m_hits   = 0;
    m_misses = 0;
  endtask

  function automatic int model_lookup(input logic [7:0] a);
    for (int i = 0; i < 4; i++) if (m_valid[i] && m_tag[i] == a) return i;
    return -1;
  endfunction

  function automatic int model_victim();
    for (int i = 0; i < 4; i++) if (!m_valid[i]) return i;
    return m_order[0];
  endfunction

  task automatic model_touch(input int e);
    int pos = -1;
    for (int k = 0; k < m_order.size(); k++) if (m_order[k] == e) pos = k;
    if (pos >= 0) m_order.delete(pos);
    m_order.push_back(e);
  endtask

  task automatic check_arrays();
    logic [31:0] et;
    logic [3:0]  ev;
    for (int i = 0; i < 4; i++) begin
      et[i*8 +: 8] = m_tag[i];
      ev[i]        = m_valid[i];
    end
    check("tag_out", bus.tag_out, et);
    check("valid_out", {28'd0, bus.valid_out}, {28'd0, ev});
`ifdef CACHE_STATS_EN
    check("hit_cnt", {24'd0, hit_cnt}, (m_hits > 255) ? 32'd255 : 32'(m_hits));
    check("miss_cnt", {24'd0, miss_cnt}, (m_misses > 255) ? 32'd255 : 32'(m_misses));
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.req = 1'b0; bus.hit = 1'b0; bus.mem_ack = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One CPU read; ack_dly = N cycles from the request cycle to the ack cycle.
  task automatic do_read(input logic [7:0] a, input int ack_dly, input logic [7:0] md);
    int idx, v;
    @(negedge clk);
    check("ready_idle", {31'd0, bus.ready}, 32'd1);
    check("rvalid_idle", {31'd0, bus.rvalid}, 32'd0);
    idx = model_lookup(a);
    bus.req  = 1'b1;
    bus.addr = a;
    bus.hit  = (idx >= 0);
    bus.sel  = (idx >= 0) ? idx[1:0] : 2'($urandom);
    @(negedge clk);
    bus.hit = 1'b0;
    if (idx >= 0) begin
      bus.req = 1'b0;
      m_hits++;
      model_touch(idx);
      check("hit_rvalid", {31'd0, bus.rvalid}, 32'd1);
      check("hit_rdata", {24'd0, bus.rdata}, {24'd0, m_data[idx]});
      check("hit_mem_req", {31'd0, bus.mem_req}, 32'd0);
    end else begin
      m_misses++;
      bus.req = 1'($urandom);
      check("fetch_mem_req", {31'd0, bus.mem_req}, 32'd1);
      check("fetch_mem_addr", {24'd0, bus.mem_addr}, {24'd0, a});
      check("fetch_ready", {31'd0, bus.ready}, 32'd0);
      for (int k = 1; k < ack_dly; k++) begin
        @(negedge clk);
        bus.req = 1'($urandom);
        check("wait_mem_req", {31'd0, bus.mem_req}, 32'd1);
      end
      bus.req      = 1'b0;
      bus.mem_ack  = 1'b1;
      bus.mem_data = md;
      @(negedge clk);
      bus.mem_ack  = 1'b0;
      bus.mem_data = 8'($urandom);
      check("fill_mem_req", {31'd0, bus.mem_req}, 32'd0);
      check("fill_rvalid", {31'd0, bus.rvalid}, 32'd0);
      @(negedge clk);
      check("miss_rvalid", {31'd0, bus.rvalid}, 32'd1);
      check("miss_rdata", {24'd0, bus.rdata}, {24'd0, md});
      v = model_victim();
      m_tag[v] = a; m_data[v] = md; m_valid[v] = 1'b1;
      model_touch(v);
    end
    check_arrays();
  endtask

  initial begin
    logic [7:0] pool [8];
    rst_n = 1'b0;
    bus.req = 1'b0; bus.addr = '0; bus.hit = 1'b0; bus.sel = '0;
    bus.mem_ack = 1'b0; bus.mem_data = '0;
    model_reset();

    // T1 reset state
    #3;
    check("rst_valid", {28'd0, bus.valid_out}, 32'd0);
    check("rst_tag", bus.tag_out, 32'd0);
    check("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    check("rst_mem_addr", {24'd0, bus.mem_addr}, 32'd0);
    check("rst_ready", {31'd0, bus.ready}, 32'd1);
    check("rst_rvalid", {31'd0, bus.rvalid}, 32'd0);
    check("rst_rdata", {24'd0, bus.rdata}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // T2 cold miss, T3 hit
    do_read(8'h10, 2, 8'hA5);
    check("t2_tag0", {24'd0, bus.tag_out[7:0]}, 32'h10);
    check("t2_valid0", {31'd0, bus.valid_out[0]}, 32'd1);
    do_read(8'h10, 1, 8'h00);
    check("t3_rdata", {24'd0, bus.rdata}, 32'hA5);

    // T4 LRU replacement
    do_reset();
    do_read(8'h10, 1, 8'h11);
    do_read(8'h20, 3, 8'h22);
    do_read(8'h30, 1, 8'h33);
    do_read(8'h40, 2, 8'h44);
    do_read(8'h10, 1, 8'h00);
    do_read(8'h50, 1, 8'h55);
    check("t4_tags", bus.tag_out, 32'h4030_5010);

    // T5 reset while fetching
    @(negedge clk);
    bus.req = 1'b1; bus.addr = 8'h77; bus.hit = 1'b0;
    @(negedge clk);
    bus.req = 1'b0;
    check("t5_mem_req_pre", {31'd0, bus.mem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_mem_req_async", {31'd0, bus.mem_req}, 32'd0);
    check("t5_valid", {28'd0, bus.valid_out}, 32'd0);
    check("t5_ready", {31'd0, bus.ready}, 32'd1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    bus.mem_ack = 1'b1; bus.mem_data = 8'hEE;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    check("t5_late_ack_req", {31'd0, bus.mem_req}, 32'd0);
    check("t5_late_ack_ready", {31'd0, bus.ready}, 32'd1);
    @(negedge clk);
    check("t5_late_ack_rvalid", {31'd0, bus.rvalid}, 32'd0);
    check_arrays();

    // Randomized traffic over a small address pool so hits and evictions mix
    do_reset();
    for (int i = 0; i < 8; i++) pool[i] = 8'($urandom);
    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        @(negedge clk);
        bus.mem_ack = 1'b1; bus.mem_data = 8'($urandom);
        @(negedge clk);
        bus.mem_ack = 1'b0;
        check("idle_ack_mem_req", {31'd0, bus.mem_req}, 32'd0);
        check("idle_ack_rvalid", {31'd0, bus.rvalid}, 32'd0);
      end
      do_read(pool[$urandom_range(0, 7)], $urandom_range(1, 4), 8'($urandom));
    end

`ifdef CACHE_STATS_EN
    // T6 counter saturation
    do_reset();
    do_read(8'h10, 1, 8'h5A);
    for (int n = 0; n < 300; n++) do_read(8'h10, 1, 8'h00);
    check("t6_hit_cnt", {24'd0, hit_cnt}, 32'hFF);
    check("t6_miss_cnt", {24'd0, miss_cnt}, 32'h01);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
